// File: rtl/boot_ctr_mc_pkg.sv
// rtl/boot_ctr_mc_pkg.sv - register selector and STATUS field positions for the boot/reset controller
package boot_ctr_mc_pkg;

    // Word index taken from byte address bits [3:2]
    typedef enum logic [1:0] {
        REG_BOOT     = 2'd0,
        REG_RESET    = 2'd1,
        REG_DURATION = 2'd2,
        REG_STATUS   = 2'd3
    } reg_sel_e;

    // STATUS layout: boot bits at the bottom, reset bits from bit 8 up
    localparam int STATUS_BOOT_LSB  = 0;
    localparam int STATUS_RESET_LSB = 8;

endpackage

// File: rtl/boot_ctr_chan.sv
// rtl/boot_ctr_chan.sv - one core's reset-pulse counter, reset output and boot-mode latch
module boot_ctr_chan #(
    parameter int CNT_W   = 8,
    parameter int DUR_DEF = 100
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             arst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] dur_i,
    input  logic             boot_nxt_i,
    output logic             boot_o,
    output logic             reset_o
);

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DUR_DEF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_q, reset_d;
    logic             boot_q, boot_d;

    // A request reloads the counter and re-latches boot mode; otherwise count down to 0 and stop
    always_comb begin
        cnt_d   = cnt_q;
        reset_d = reset_q;
        boot_d  = boot_q;
        if (start_i) begin
            cnt_d   = dur_i;
            reset_d = (dur_i != '0);
            boot_d  = boot_nxt_i;
        end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNT_ONE;
            reset_d = (cnt_q != CNT_ONE);
        end
    end

    // Reset state is the start of the power-on pulse; cke low freezes the channel
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q   <= CNT_RST;
            reset_q <= 1'b1;
            boot_q  <= 1'b1;
        end else if (cke_i) begin
            cnt_q   <= cnt_d;
            reset_q <= reset_d;
            boot_q  <= boot_d;
        end
    end

    assign reset_o = reset_q;
    assign boot_o  = boot_q;

endmodule

// File: rtl/boot_ctr_mc.sv
// rtl/boot_ctr_mc.sv - multi-core boot/reset controller on the IOb native bus
module boot_ctr_mc #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int N_CPU   = 2,
    parameter int CNT_W   = 8,
    parameter int DUR_DEF = 100
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    output logic [N_CPU-1:0]      boot_o,
    output logic [N_CPU-1:0]      cpu_reset_o
);
    import boot_ctr_mc_pkg::*;

    localparam logic [CNT_W-1:0] DUR_RST = CNT_W'(DUR_DEF);
    localparam logic [CNT_W-1:0] DUR_MIN = CNT_W'(1);

    logic [N_CPU-1:0]  boot_reg_q, boot_reg_d;
    logic [CNT_W-1:0]  dur_q, dur_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              wr_en;
    logic              rd_en;
    reg_sel_e          sel;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rd_val;
    logic [CNT_W-1:0]  dur_new;
    logic [N_CPU-1:0]  start;
    logic [N_CPU-1:0]  chan_boot;
    logic [N_CPU-1:0]  chan_reset;
    logic              unused_bits;

    // Only the word select is decoded; the rest of the address is don't-care
    assign unused_bits = ^{iob_addr_i, iob_wdata_i};

    // Decode the request and expand byte strobes into a per-bit write mask
    always_comb begin
        wr_en = iob_avalid_i && (iob_wstrb_i != '0);
        rd_en = iob_avalid_i && (iob_wstrb_i == '0);
        sel   = reg_sel_e'(iob_addr_i[3:2]);
        wmask = '0;
        for (int b = 0; b < DATA_W; b++) begin
            wmask[b] = iob_wstrb_i[b/8];
        end
    end

    // Register file next-state: masked writes, DURATION never stored as zero, RESET is a strobe
    always_comb begin
        boot_reg_d = boot_reg_q;
        dur_d      = dur_q;
        dur_new    = (dur_q & ~wmask[CNT_W-1:0]) | (iob_wdata_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
        start      = '0;
        if (wr_en) begin
            case (sel)
                REG_BOOT: begin
                    boot_reg_d = (boot_reg_q & ~wmask[N_CPU-1:0])
                               | (iob_wdata_i[N_CPU-1:0] & wmask[N_CPU-1:0]);
                end
                REG_RESET: begin
                    start = iob_wdata_i[N_CPU-1:0] & wmask[N_CPU-1:0];
                end
                REG_DURATION: begin
                    dur_d = (dur_new == '0) ? DUR_MIN : dur_new;
                end
                default: ;
            endcase
        end
    end

    // Read mux; value is captured in the request cycle and returned one cycle later
    always_comb begin
        rd_val = '0;
        case (sel)
            REG_BOOT:     rd_val[N_CPU-1:0] = boot_reg_q;
            REG_RESET:    rd_val[N_CPU-1:0] = chan_reset;
            REG_DURATION: rd_val[CNT_W-1:0] = dur_q;
            REG_STATUS: begin
                rd_val[STATUS_BOOT_LSB +: N_CPU]  = chan_boot;
                rd_val[STATUS_RESET_LSB +: N_CPU] = chan_reset;
            end
            default: ;
        endcase
        rvalid_d = rd_en;
        rdata_d  = rd_en ? rd_val : '0;
    end

    // Software-visible registers and read-response flops, frozen while cke is low
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            boot_reg_q <= '1;
            dur_q      <= DUR_RST;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else if (cke_i) begin
            boot_reg_q <= boot_reg_d;
            dur_q      <= dur_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    for (genvar g = 0; g < N_CPU; g++) begin : g_chan
        boot_ctr_chan #(
            .CNT_W   (CNT_W),
            .DUR_DEF (DUR_DEF)
        ) u_chan (
            .clk_i      (clk_i),
            .cke_i      (cke_i),
            .arst_i     (arst_i),
            .start_i    (start[g]),
            .dur_i      (dur_q),
            .boot_nxt_i (boot_reg_q[g]),
            .boot_o     (chan_boot[g]),
            .reset_o    (chan_reset[g])
        );
    end

    assign iob_ready_o  = 1'b1;
    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;
    assign boot_o       = chan_boot;
    assign cpu_reset_o  = chan_reset;

endmodule
